// File: rtl/sdram_burst_sched.sv
// Burst scheduler for sdram_control: treats SDRAM as a circular burst ring,
// arbitrating write/read bursts and holding the burst address stable.
module sdram_burst_sched #(
    parameter int ASIZE       = 12,
    parameter int BSIZE       = 2,
    parameter int SC_BL       = 8,
    parameter int BPR_BITS    = 6,
    parameter int ROW_BITS    = 12,
    parameter int FW          = 9,
    parameter int RFIFO_DEPTH = 512,
    parameter int TMO         = 1024
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Init_done,
    input  logic                         Wr_en,
    input  logic                         Rd_en,
    input  logic [BSIZE-1:0]             Bank_sel,
    input  logic                         Addr_clr,
    input  logic [FW-1:0]                Wfifo_usedw,
    input  logic [FW-1:0]                Rfifo_usedw,
    input  logic                         Wdata_done,
    input  logic                         Rdata_done,
    output logic                         Wr,
    output logic                         Rd,
    output logic [ASIZE-1:0]             Caddr,
    output logic [ASIZE-1:0]             Raddr,
    output logic [BSIZE-1:0]             Baddr,
    output logic [BPR_BITS+ROW_BITS:0]   Fill,
    output logic                         Busy,
    output logic                         Err
);

    localparam int PW  = BPR_BITS + ROW_BITS;
    localparam int BLS = $clog2(SC_BL);
    localparam int CW  = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     sel_ptr;
    logic [CW-1:0]   tmo_cnt;
    logic            last_wr;
    logic            clr_pend;
    logic            ring_empty;
    logic            ring_full;
    logic            wr_elig;
    logic            rd_elig;
    logic            grant_wr;
    logic            grant_rd;
    logic            wr_fin;
    logic            rd_fin;
    logic            tmo_hit;
    logic            burst_end;
    logic            in_wait;
    logic            in_req;
    logic [ASIZE-1:0] col_n;
    logic [ASIZE-1:0] row_n;

    assign ring_empty = (wr_ptr == rd_ptr);
    assign ring_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign wr_elig = Wr_en && (int'(Wfifo_usedw) >= SC_BL) && !ring_full;
    assign rd_elig = Rd_en && ((RFIFO_DEPTH - int'(Rfifo_usedw)) >= SC_BL)
                     && !ring_empty;

    assign in_req  = (state == WR_REQ) || (state == RD_REQ);
    assign in_wait = (state == WR_WAIT) || (state == RD_WAIT);

    assign Wr   = (state == WR_REQ);
    assign Rd   = (state == RD_REQ);
    assign Busy = in_req || in_wait;
    assign Fill = wr_ptr - rd_ptr;

    assign burst_end = wr_fin || rd_fin || tmo_hit;

    assign sel_ptr = grant_wr ? wr_ptr : rd_ptr;
    assign col_n   = ASIZE'(sel_ptr[BPR_BITS-1:0]) << BLS;
    assign row_n   = ASIZE'(sel_ptr[PW-1:BPR_BITS]);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Round robin: with both eligible, write wins only if read went last.
    always_comb begin
        state_n  = state;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        wr_fin   = 1'b0;
        rd_fin   = 1'b0;
        tmo_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Init_done) state_n = ARB;
            end
            ARB: begin
                if (!Addr_clr) begin
                    if (wr_elig && (!rd_elig || !last_wr)) begin
                        grant_wr = 1'b1;
                        state_n  = WR_REQ;
                    end else if (rd_elig) begin
                        grant_rd = 1'b1;
                        state_n  = RD_REQ;
                    end
                end
            end
            WR_REQ: state_n = WR_WAIT;
            RD_REQ: state_n = RD_WAIT;
            WR_WAIT: begin
                if (Wdata_done) begin
                    wr_fin  = 1'b1;
                    state_n = ARB;
                end else if (tmo_cnt == CW'(TMO - 1)) begin
                    tmo_hit = 1'b1;
                    state_n = ARB;
                end
            end
            RD_WAIT: begin
                if (Rdata_done) begin
                    rd_fin  = 1'b1;
                    state_n = ARB;
                end else if (tmo_cnt == CW'(TMO - 1)) begin
                    tmo_hit = 1'b1;
                    state_n = ARB;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tmo_cnt  <= '0;
            last_wr  <= 1'b0;
            clr_pend <= 1'b0;
            Err      <= 1'b0;
            Caddr    <= '0;
            Raddr    <= '0;
            Baddr    <= '0;
        end else begin
            if (in_req)       tmo_cnt <= '0;
            else if (in_wait) tmo_cnt <= tmo_cnt + 1'b1;

            if (grant_wr || grant_rd) begin
                Caddr <= col_n;
                Raddr <= row_n;
                Baddr <= Bank_sel;
            end

            if (tmo_hit) Err <= 1'b1;

            if (wr_fin)      last_wr <= 1'b1;
            else if (rd_fin) last_wr <= 1'b0;

            // A clear seen mid-burst replaces the completing increment.
            if (!Busy) begin
                if (Addr_clr) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
            end else if (burst_end) begin
                if (clr_pend || Addr_clr) begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    clr_pend <= 1'b0;
                end else if (wr_fin) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end else if (rd_fin) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end else if (Addr_clr) begin
                clr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched with a small controller responder;
// the ring is shrunk to 4 rows so full and wrap are reachable quickly.
module tb_sdram_burst_sched;

    localparam int PWT = 8;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Init_done = 1'b0;
    logic        Wr_en = 1'b0;
    logic        Rd_en = 1'b0;
    logic [1:0]  Bank_sel = 2'd0;
    logic        Addr_clr = 1'b0;
    logic [8:0]  Wfifo_usedw = 9'd0;
    logic [8:0]  Rfifo_usedw = 9'd0;
    logic        Wdata_done = 1'b0;
    logic        Rdata_done = 1'b0;
    logic        Wr;
    logic        Rd;
    logic [11:0] Caddr;
    logic [11:0] Raddr;
    logic [1:0]  Baddr;
    logic [PWT:0] Fill;
    logic        Busy;
    logic        Err;

    sdram_burst_sched #(.ROW_BITS(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Init_done(Init_done),
        .Wr_en(Wr_en), .Rd_en(Rd_en), .Bank_sel(Bank_sel),
        .Addr_clr(Addr_clr), .Wfifo_usedw(Wfifo_usedw),
        .Rfifo_usedw(Rfifo_usedw), .Wdata_done(Wdata_done),
        .Rdata_done(Rdata_done), .Wr(Wr), .Rd(Rd), .Caddr(Caddr),
        .Raddr(Raddr), .Baddr(Baddr), .Fill(Fill), .Busy(Busy),
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [11:0] c;
        logic [11:0] r;
        logic [1:0]  b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   mwp = 0;
    int   mrp = 0;
    int   wr_left = 0;
    int   rd_left = 0;
    int   wr_pulses = 0;
    int   rd_pulses = 0;
    int   wr_dones = 0;
    int   rd_dones = 0;
    int   dly = 0;
    int   done_dly = 3;
    logic dwr = 1'b0;
    logic withhold = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic w, input int p);
        exp_t e;
        e.wr = w;
        e.c  = 12'((p % 64) * 8);
        e.r  = 12'((p / 64) % 4);
        e.b  = Bank_sel;
        exp_q.push_back(e);
    endtask

    // Controller model: scoreboard check on each request, then a done pulse.
    always @(negedge Clk) begin
        exp_t e;
        Wdata_done = 1'b0;
        Rdata_done = 1'b0;
        if (Wr || Rd) begin
            check("wr_rd_excl", 32'(Wr & Rd), 0);
            check("busy_req", 32'(Busy), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_req", {30'd0, Wr, Rd}, 0);
            end else begin
                e = exp_q.pop_front();
                check("req_kind", 32'(Wr), 32'(e.wr));
                check("caddr", 32'(Caddr), 32'(e.c));
                check("raddr", 32'(Raddr), 32'(e.r));
                check("baddr", 32'(Baddr), 32'(e.b));
            end
            if (Wr) begin
                wr_pulses++;
                if (wr_left > 0) wr_left--;
                if (wr_left == 0) Wr_en = 1'b0;
            end else begin
                rd_pulses++;
                if (rd_left > 0) rd_left--;
                if (rd_left == 0) Rd_en = 1'b0;
            end
            if (withhold) begin
                withhold = 1'b0;
            end else begin
                dly = done_dly;
                dwr = Wr;
            end
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                if (dwr) begin
                    Wdata_done = 1'b1;
                    wr_dones++;
                end else begin
                    Rdata_done = 1'b1;
                    rd_dones++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic wait_dones(input int wt, input int rt, input int budget);
        int k = 0;
        while ((wr_dones < wt || rd_dones < rt) && k < budget) begin
            @(negedge Clk);
            k++;
        end
        if (wr_dones < wt || rd_dones < rt)
            check("wait_dones_tmo", 32'(wr_dones + rd_dones), 32'(wt + rt));
        cycles(3);
    endtask

    task automatic wait_wr_pulse(input int target);
        int k = 0;
        while (wr_pulses < target && k < 100) begin
            @(negedge Clk);
            k++;
        end
        check("wait_pulse", 32'(wr_pulses >= target), 1);
    endtask

    task automatic do_writes(input int n);
        int t0 = wr_dones;
        for (int i = 0; i < n; i++) begin
            push_req(1'b1, mwp);
            mwp++;
        end
        wr_left = n;
        Wr_en = 1'b1;
        wait_dones(t0 + n, rd_dones, n * 20 + 50);
    endtask

    task automatic do_reads(input int n);
        int t0 = rd_dones;
        for (int i = 0; i < n; i++) begin
            push_req(1'b0, mrp);
            mrp++;
        end
        rd_left = n;
        Rd_en = 1'b1;
        wait_dones(wr_dones, t0 + n, n * 20 + 50);
    endtask

    initial begin
        int  p0;
        logic lw;
        cycles(3);
        check("rst_wr", 32'(Wr), 0);
        check("rst_rd", 32'(Rd), 0);
        check("rst_caddr", 32'(Caddr), 0);
        check("rst_raddr", 32'(Raddr), 0);
        check("rst_baddr", 32'(Baddr), 0);
        check("rst_fill", 32'(Fill), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_err", 32'(Err), 0);

        Rst_n = 1'b1;
        Init_done = 1'b1;
        Bank_sel = 2'd2;
        Wfifo_usedw = 9'd8;
        Rd_en = 1'b1;
        cycles(20);
        check("empty_no_rd", 32'(rd_pulses), 0);
        Rd_en = 1'b0;

        do_writes(1);
        check("fill_1", 32'(Fill), 1);
        do_writes(64);
        check("fill_65", 32'(Fill), 65);

        p0 = rd_pulses;
        Rfifo_usedw = 9'd505;
        Rd_en = 1'b1;
        rd_left = 1;
        cycles(20);
        check("rfifo_space_no_rd", 32'(rd_pulses), 32'(p0));
        Rd_en = 1'b0;
        rd_left = 0;
        Rfifo_usedw = 9'd504;

        p0 = wr_pulses;
        Wfifo_usedw = 9'd7;
        Wr_en = 1'b1;
        wr_left = 1;
        cycles(20);
        check("wfifo_low_no_wr", 32'(wr_pulses), 32'(p0));
        Wr_en = 1'b0;
        wr_left = 0;
        Wfifo_usedw = 9'd8;

        lw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (lw) push_req(1'b0, mrp++);
            else    push_req(1'b1, mwp++);
            lw = ~lw;
        end
        p0 = wr_dones;
        wr_left = 4;
        rd_left = 4;
        Wr_en = 1'b1;
        Rd_en = 1'b1;
        wait_dones(p0 + 4, 4, 300);
        check("fill_alt", 32'(Fill), 65);

        do_writes(191);
        check("fill_full", 32'(Fill), 256);
        p0 = wr_pulses;
        wr_left = 5;
        Wr_en = 1'b1;
        cycles(30);
        check("full_no_wr", 32'(wr_pulses), 32'(p0));
        Wr_en = 1'b0;
        wr_left = 0;
        check("err_before", 32'(Err), 0);

        do_reads(1);
        check("fill_255", 32'(Fill), 255);

        p0 = wr_pulses;
        push_req(1'b1, mwp);
        push_req(1'b1, mwp);
        mwp++;
        withhold = 1'b1;
        wr_left = 2;
        Wr_en = 1'b1;
        wait_dones(wr_dones + 1, rd_dones, 1500);
        check("tmo_err", 32'(Err), 1);
        check("tmo_reissue", 32'(wr_pulses - p0), 2);
        check("tmo_fill", 32'(Fill), 256);

        do_reads(1);
        p0 = wr_pulses;
        push_req(1'b1, mwp);
        done_dly = 8;
        wr_left = 1;
        Wr_en = 1'b1;
        wait_wr_pulse(p0 + 1);
        @(negedge Clk);
        Addr_clr = 1'b1;
        @(negedge Clk);
        Addr_clr = 1'b0;
        wait_dones(wr_dones + 1, rd_dones, 100);
        done_dly = 3;
        mwp = 0;
        mrp = 0;
        check("clr_fill", 32'(Fill), 0);
        check("clr_err_kept", 32'(Err), 1);
        do_writes(1);
        check("clr_fill_1", 32'(Fill), 1);

        Addr_clr = 1'b1;
        @(negedge Clk);
        Addr_clr = 1'b0;
        cycles(2);
        check("arb_clr_fill", 32'(Fill), 0);
        mwp = 0;
        mrp = 0;

        p0 = wr_pulses;
        push_req(1'b1, mwp);
        withhold = 1'b1;
        wr_left = 1;
        Wr_en = 1'b1;
        wait_wr_pulse(p0 + 1);
        cycles(3);
        Rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_err", 32'(Err), 0);
        check("mid_rst_fill", 32'(Fill), 0);
        check("mid_rst_caddr", 32'(Caddr), 0);
        check("mid_rst_baddr", 32'(Baddr), 0);
        check("sb_empty", 32'(exp_q.size()), 0);
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
